// File: rtl/spi_responder.sv
// SPI mode-3 register responder: 40-bit frames {rw, addr, data}.
// Read data is returned one frame later behind a status byte.
module spi_responder #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        cs_n_in,
  input  logic        sck_in,
  input  logic        sdi_in,
  output logic        sdo_out,
  output logic        sdo_oe_out,
  input  logic [7:0]  status_in,
  output logic        wr_valid_out,
  output logic [6:0]  wr_addr_out,
  output logic [31:0] wr_data_out,
  output logic        frame_err_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic [5:0] FRAME_BITS = 6'd40;
  localparam logic [5:0] CNT_SAT    = 6'd41;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   cs_prev_q;
  logic                   sck_prev_q;
  logic                   armed_q;
  logic                   armed_d;

  logic cs_s;
  logic sck_s;
  logic sdi_s;
  logic cs_fall;
  logic cs_rise;
  logic sck_rise;
  logic sck_fall;

  state_e      state_q, state_d;
  logic [39:0] tx_q, tx_d;
  logic [39:0] rx_q, rx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rdbuf_q, rdbuf_d;
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ferr_q, ferr_d;
  logic        reg_we;

  logic [31:0] regs_q [NUM_REGS];
  logic [6:0]  rx_addr;
  logic [31:0] rx_data;
  logic        in_range;
  logic [31:0] rd_word;

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  // A CS low that was already low at reset release must not open a frame;
  // armed_q only rises once a real (post-reset) high level has been seen.
  assign armed_d  = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  assign rx_addr  = rx_q[38:32];
  assign rx_data  = rx_q[31:0];
  assign in_range = ({25'd0, rx_addr} < 32'(NUM_REGS));

  // Synchronize pad inputs and keep one more stage for edge detection.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '1;
      sdi_sync_q <= '0;
      vld_q      <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_in};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
      armed_q    <= armed_d;
    end
  end

  // Register-file read mux for the addressed word.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_addr == 7'(i)) rd_word = regs_q[i];
    end
  end

  // Next-state and datapath updates for the frame FSM.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    rdbuf_d    = rdbuf_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ferr_d     = 1'b0;
    reg_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          tx_d    = {status_in, rdbuf_q};
          rx_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = COMMIT;
        end else begin
          if (sck_rise) begin
            rx_d = {rx_q[38:0], sdi_s};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 6'd1;
          end
          // The leading falling edge precedes the first sample; bit 39
          // must stay on the line until it has been captured.
          if (sck_fall && cnt_q != '0) begin
            tx_d = {tx_q[38:0], 1'b0};
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == FRAME_BITS) begin
          if (rx_q[39]) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = rx_addr;
            wr_data_d  = rx_data;
            reg_we     = in_range;
          end else begin
            rdbuf_d = in_range ? rd_word : '0;
          end
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      rdbuf_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      rdbuf_q    <= rdbuf_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ferr_q     <= ferr_d;
    end
  end

  // Register file, written only on an in-range committed write.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rx_addr == 7'(i)) regs_q[i] <= rx_data;
      end
    end
  end

  assign sdo_oe_out    = (state_q == SHIFT);
  assign sdo_out       = sdo_oe_out & tx_q[39];
  assign wr_valid_out  = wr_valid_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign frame_err_out = ferr_q;

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers in the internal register file (1..128).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for cs_n_in, sck_in and sdi_in (>=2).
REQ-003 clk_in  input  1  system clock; single clock domain for all logic.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 cs_n_in  input  1  SPI chip select, active low, asynchronous to clk_in.
REQ-006 sck_in  input  1  SPI clock, mode 3 (idles high), asynchronous to clk_in.
REQ-007 sdi_in  input  1  SPI data from initiator, MSB first.
REQ-008 sdo_out  output  1  SPI data to initiator, MSB first.
REQ-009 sdo_oe_out  output  1  high while the frame is selected; pad tristate control.
REQ-010 status_in  input  8  status byte returned in the first 8 bits of every response.
REQ-011 wr_valid_out  output  1  one-cycle pulse on each committed write.
REQ-012 wr_addr_out  output  7  register address of the committed write; held until the next commit.
REQ-013 wr_data_out  output  32  data of the committed write; held until the next commit.
REQ-014 frame_err_out  output  1  one-cycle pulse when a frame ends with a bit count other than 40.

Function
REQ-015 SHALL pass cs_n_in, sck_in and sdi_in through SYNC_STAGES flops; all edge detection SHALL use synchronized values only; supported SCK frequency <= clk_in/4.
REQ-016 Frame format: 40 bits = {rw, addr[6:0], data[31:0]}; rw=1 is write, rw=0 is read.
REQ-017 States: IDLE, SHIFT, COMMIT; IDLE->SHIFT on synchronized CS falling edge; SHIFT->COMMIT on CS rising edge; COMMIT->IDLE after exactly one cycle.
REQ-018 On IDLE->SHIFT, SHALL load the tx shift register with {status_in, read_buf}, clear the bit counter and present bit 39 on sdo_out in the same cycle the state becomes SHIFT.
REQ-019 In SHIFT, on each synchronized SCK rising edge, SHALL shift sdi into the rx shift register (LSB in) and increment the bit counter, saturating at 41.
REQ-020 In SHIFT, on each synchronized SCK falling edge, SHALL advance the tx shift register by one bit; after the 40th bit sdo_out SHALL be 0.
REQ-021 sdo_oe_out SHALL be 1 exactly in SHIFT; sdo_out SHALL be 0 whenever sdo_oe_out is 0.
REQ-022 COMMIT with count==40, rw=1, addr<NUM_REGS: regfile[addr]<=data; wr_valid_out pulses; wr_addr_out/wr_data_out update in the same cycle.
REQ-023 COMMIT with count==40, rw=1, addr>=NUM_REGS: no regfile change; wr_valid_out still pulses with addr/data (system decodes it).
REQ-024 COMMIT with count==40, rw=0: read_buf<=regfile[addr] if addr<NUM_REGS, else 0; no wr_valid_out pulse.
REQ-025 Read data SHALL be pipelined one frame: a response carries read_buf as set by the previous committed frame (a write frame leaves read_buf unchanged).
REQ-026 COMMIT with count!=40 (short or over-long): no regfile, read_buf or wr_* change; frame_err_out pulses one cycle.
REQ-027 An SCK edge and a CS rising edge detected in the same cycle: CS edge takes priority, SCK edge is ignored.
REQ-028 SCK edges while in IDLE SHALL be ignored.

Reset
REQ-029 reset_in SHALL force state IDLE, all regfile entries, read_buf, shift registers, counter and wr_addr_out/wr_data_out to 0, and wr_valid_out, frame_err_out, sdo_out, sdo_oe_out to 0 on the next clock edge.
REQ-030 Synchronizer flops SHALL reset to idle levels (cs_n=1, sck=1, sdi=0), so a CS held low across reset release is not treated as a new frame until it goes high and low again.
REQ-031 Reset mid-frame SHALL abort the frame with no commit and no frame_err_out pulse.

Verification
REQ-032 Write 0x80_DEADBEEF (addr 0) -> one wr_valid_out pulse, wr_addr_out=0x00, wr_data_out=0xDEADBEEF, regfile[0]=0xDEADBEEF.
REQ-033 Read 0x00_00000000 after REQ-032, status_in=0xA5 -> response 0xA5_00000000; second identical read -> response 0xA5_DEADBEEF.
REQ-034 39-bit frame of 0x81_12345678 -> frame_err_out pulses, no wr_valid_out, regfile[1] stays 0; a following 41-bit frame also pulses frame_err_out.
REQ-035 Read addr 0x7F with NUM_REGS=16, then read again -> second response data = 0x00000000; write to 0x7F -> wr_valid_out pulses, regfile unchanged.
REQ-036 Assert reset_in after 20 bits of a write frame -> no commit, no error pulse; sdo_oe_out=0; the next full frame is processed normally.
REQ-037 SCK at clk_in/4 with CS rising in the same cycle as the last SCK rising edge -> frame counted as 39 bits, frame_err_out pulses.
